// File: rtl/fir_mac_datapath_if.sv
// Strobe/data bundle between the FIR sequencer (master) and the MAC datapath (slave).
// AW must match $clog2(Num_coef) of the attached datapath.
interface fir_mac_datapath_if #(
    parameter int AW     = 5,
    parameter int W_in   = 16,
    parameter int W_coef = 16,
    parameter int W_out  = 16
);
    logic signed [W_in-1:0]   din;
    logic                     ce_Reg;
    logic        [AW-1:0]     addr;
    logic                     rst_Acc;
    logic                     ce_Acc;
    logic                     coef_we;
    logic        [AW-1:0]     coef_addr;
    logic signed [W_coef-1:0] coef_din;
    logic signed [W_out-1:0]  dout;
    logic                     val_out;

    modport master (
        output din, ce_Reg, addr, rst_Acc, ce_Acc, coef_we, coef_addr, coef_din,
        input  dout, val_out
    );

    modport slave (
        input  din, ce_Reg, addr, rst_Acc, ce_Acc, coef_we, coef_addr, coef_din,
        output dout, val_out
    );
endinterface

// File: rtl/fir_mac_datapath.sv
// Serial multiply-accumulate datapath of the FIR filter: delay line, coefficient memory,
// two-stage MAC pipeline (product, accumulate) and a saturating output stage.
module fir_mac_datapath #(
    parameter int Num_coef = 17,
    parameter int W_in     = 16,
    parameter int W_coef   = 16,
    parameter int W_out    = 16,
    parameter int SHIFT    = 15
) (
    input logic clk,
    input logic rst,
    fir_mac_datapath_if.slave bus
);
    localparam int AW     = $clog2(Num_coef);
    localparam int W_prod = W_in + W_coef;
    localparam int W_acc  = W_prod + AW;
    localparam logic signed [W_acc-1:0] OUT_MAX = {{(W_acc-W_out+1){1'b0}}, {(W_out-1){1'b1}}};
    localparam logic signed [W_acc-1:0] OUT_MIN = {{(W_acc-W_out+1){1'b1}}, {(W_out-1){1'b0}}};

    logic signed [W_in-1:0]   x [Num_coef];
    logic signed [W_coef-1:0] h [Num_coef];

    logic                     addr_ok;
    logic                     addr_last;
    logic                     coef_addr_ok;
    logic signed [W_in-1:0]   x_sel;
    logic signed [W_coef-1:0] h_sel;
    logic signed [W_prod-1:0] prod;

    logic signed [W_prod-1:0] p;
    logic                     v1;
    logic                     c1;
    logic                     l1;

    logic signed [W_acc-1:0]  acc;
    logic signed [W_acc-1:0]  sum;
    logic signed [W_acc-1:0]  shifted;
    logic signed [W_out-1:0]  sat_val;
    logic signed [W_out-1:0]  dout_q;
    logic                     val_q;

    // Range checks widened by one bit so a power-of-two tap count cannot wrap to zero.
    assign addr_ok      = {1'b0, bus.addr} < (AW+1)'(Num_coef);
    assign coef_addr_ok = {1'b0, bus.coef_addr} < (AW+1)'(Num_coef);
    assign addr_last    = bus.addr == AW'(Num_coef - 1);

    assign x_sel = addr_ok ? x[bus.addr] : '0;
    assign h_sel = addr_ok ? h[bus.addr] : '0;
    assign prod  = W_prod'(x_sel) * W_prod'(h_sel);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Num_coef; i++) x[i] <= '0;
        end else if (bus.ce_Reg) begin
            x[0] <= bus.din;
            for (int i = 1; i < Num_coef; i++) x[i] <= x[i-1];
        end
    end

    // Coefficients survive reset so a reset does not force a reload from the host.
    always_ff @(posedge clk) begin
        if (bus.coef_we && coef_addr_ok) h[bus.coef_addr] <= bus.coef_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p  <= '0;
            v1 <= 1'b0;
            c1 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            p  <= (bus.ce_Acc && addr_ok) ? prod : '0;
            v1 <= bus.ce_Acc;
            c1 <= bus.rst_Acc;
            l1 <= bus.ce_Acc && addr_last;
        end
    end

    // A pending clear (c1) makes this term the first of a new sum.
    always_comb begin
        sum     = (c1 ? '0 : acc) + {{AW{p[W_prod-1]}}, p};
        shifted = sum >>> SHIFT;
        sat_val = shifted[W_out-1:0];
        if (shifted > OUT_MAX)      sat_val = OUT_MAX[W_out-1:0];
        else if (shifted < OUT_MIN) sat_val = OUT_MIN[W_out-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            dout_q <= '0;
            val_q  <= 1'b0;
        end else begin
            if (v1)      acc <= sum;
            else if (c1) acc <= '0;
            if (l1) begin
                dout_q <= sat_val;
                val_q  <= 1'b1;
            end else begin
                val_q  <= 1'b0;
            end
        end
    end

    assign bus.dout    = dout_q;
    assign bus.val_out = val_q;
endmodule

// File: tb/tb_fir_mac_datapath.sv
// Bench for fir_mac_datapath: a default instance and a SHIFT=0/W_out=32 instance share
// one stimulus stream and are checked each cycle against a sum-of-products model.
module tb_fir_mac_datapath;
    localparam int NUM = 17;
    localparam int AW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_mac_datapath_if #(.AW(AW), .W_in(16), .W_coef(16), .W_out(16)) busA ();
    fir_mac_datapath_if #(.AW(AW), .W_in(16), .W_coef(16), .W_out(32)) busB ();

    fir_mac_datapath dutA (.clk(clk), .rst(rst), .bus(busA));
    fir_mac_datapath #(.SHIFT(0), .W_out(32)) dutB (.clk(clk), .rst(rst), .bus(busB));

    int checks = 0;
    int passes = 0;

    typedef struct { longint due; longint sum; } expEntry_t;
    expEntry_t q[$];
    longint    mx [NUM];
    longint    mh [NUM];
    longint    msum = 0;
    longint    cyc  = 0;
    longint    expA = 0;
    longint    expB = 0;
    logic      expV;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic longint satShift(input longint s, input int sh, input int w);
        longint v, hi, lo;
        v  = s >>> sh;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Model: the sweep result is the running sum of x[k]*h[k] over the terms issued since the last clear.
    task automatic modelStep();
        longint t;
        if (busA.ce_Acc) begin
            t = (busA.addr < NUM) ? mx[busA.addr] * mh[busA.addr] : 0;
            msum = busA.rst_Acc ? t : msum + t;
            if (busA.addr == NUM - 1) q.push_back('{due: cyc + 2, sum: msum});
        end else if (busA.rst_Acc) begin
            msum = 0;
        end
        if (busA.coef_we && busA.coef_addr < NUM) mh[busA.coef_addr] = longint'(busA.coef_din);
        if (busA.ce_Reg) begin
            for (int i = NUM - 1; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = longint'(busA.din);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) begin
            mx[i] = 0;
            mh[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            expV = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                expV = 1'b1;
                expA = satShift(q[0].sum, 15, 16);
                expB = satShift(q[0].sum, 0, 32);
                void'(q.pop_front());
            end
            if (!rst) begin
                expV = 1'b0;
                expA = 0;
                expB = 0;
                msum = 0;
                q.delete();
                for (int i = 0; i < NUM; i++) mx[i] = 0;
            end
            checkOutput("val_out A", longint'(busA.val_out), longint'(expV));
            checkOutput("val_out B", longint'(busB.val_out), longint'(expV));
            checkOutput("dout A", longint'(busA.dout), expA);
            checkOutput("dout B", longint'(busB.dout), expB);
            if (rst) modelStep();
        end
    end

    task automatic applyStimulus(input logic signed [15:0] d, input logic ceReg, input logic [4:0] a,
                                 input logic rAcc, input logic cAcc, input logic we,
                                 input logic [4:0] ca, input logic signed [15:0] cd);
        busA.din = d;  busA.ce_Reg = ceReg; busA.addr = a; busA.rst_Acc = rAcc;
        busA.ce_Acc = cAcc; busA.coef_we = we; busA.coef_addr = ca; busA.coef_din = cd;
        busB.din = d;  busB.ce_Reg = ceReg; busB.addr = a; busB.rst_Acc = rAcc;
        busB.ce_Acc = cAcc; busB.coef_we = we; busB.coef_addr = ca; busB.coef_din = cd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(16'sd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 16'sd0);
    endtask

    task automatic push(input logic signed [15:0] s);
        applyStimulus(s, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 16'sd0);
    endtask

    task automatic writeCoef(input logic [4:0] a, input logic signed [15:0] v);
        applyStimulus(16'sd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, a, v);
    endtask

    // One sweep of terms 0..16; badAt inserts an addr=31 term, abortAt replaces that term by a reset pulse.
    task automatic sweep(input int badAt, input int abortAt, input int tail);
        for (int k = 0; k < NUM; k++) begin
            if (k == abortAt) begin
                rst = 1'b0;
                idle(1);
                rst = 1'b1;
                idle(tail);
                return;
            end
            applyStimulus(16'sd0, 1'b0, 5'(k), k == 0, 1'b1, 1'b0, 5'd0, 16'sd0);
            if (k == badAt) applyStimulus(16'sd0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b0, 5'd0, 16'sd0);
        end
        idle(tail);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(2);
        for (int k = 0; k < NUM; k++) writeCoef(5'(k), 16'(k + 1));

        $display("[TB] reset with toggling inputs");
        rst = 1'b0;
        for (int i = 0; i < 6; i++)
            applyStimulus(16'(i * 37 + 5), i[0], 5'(i), i[1], 1'b1, 1'b0, 5'd0, 16'sd0);
        checkOutput("reset dout A", longint'(busA.dout), 0);
        checkOutput("reset val_out A", longint'(busA.val_out), 0);
        rst = 1'b1;
        idle(1);
        sweep(-1, -1, 2);
        checkOutput("zero line sweep B", longint'(busB.dout), 0);

        $display("[TB] impulse response");
        for (int s = 0; s <= NUM; s++) begin
            push(s == 0 ? 16'sd1 : 16'sd0);
            sweep(-1, -1, 2);
            checkOutput("impulse B", longint'(busB.dout), (s < NUM) ? longint'(s + 1) : 0);
        end
        checkOutput("impulse A", longint'(busA.dout), 0);

        $display("[TB] back-to-back sweeps");
        push(16'sd1);
        push(16'sd0);
        sweep(-1, -1, 0);
        sweep(-1, -1, 2);
        checkOutput("back-to-back B", longint'(busB.dout), 2);

        $display("[TB] out-of-range term");
        for (int i = 0; i < 3; i++) push(16'sd0);
        sweep(8, -1, 2);
        checkOutput("addr31 term B", longint'(busB.dout), 5);

        $display("[TB] reset mid-sweep");
        sweep(-1, 8, 2);
        checkOutput("aborted sweep B", longint'(busB.dout), 0);
        push(16'sd1);
        sweep(-1, -1, 2);
        checkOutput("post-abort sweep B", longint'(busB.dout), 1);

        $display("[TB] saturation");
        for (int k = 0; k < NUM; k++) writeCoef(5'(k), 16'sh7FFF);
        for (int i = 0; i < NUM; i++) push(16'sh7FFF);
        sweep(-1, -1, 2);
        checkOutput("sat pos A", longint'(busA.dout), 32767);
        checkOutput("sat pos B", longint'(busB.dout), 64'sd2147483647);
        for (int i = 0; i < NUM; i++) push(-16'sd32768);
        sweep(-1, -1, 2);
        checkOutput("sat neg A", longint'(busA.dout), -32768);
        checkOutput("sat neg B", longint'(busB.dout), -64'sd2147483648);

        idle(3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
